// File: rtl/cpu_pkg.sv
// Shared constants and the write-back FIFO entry type for the register datapath.
//   DATA_W   : register width
//   NREG     : number of architectural registers
//   AW       : register address width
//   WB_DEPTH : default depth of the memory write-back FIFO
package cpu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NREG     = 8;
  localparam int unsigned AW       = $clog2(NREG);
  localparam int unsigned WB_DEPTH = 4;

  // One queued memory write; live=0 marks an entry overtaken by a newer ALU write.
  typedef struct packed {
    logic              live;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for memory load write-backs with squash-by-address.
// Ports:
//   clk, rst              : clock, async active-high reset
//   push, push_addr/data  : enqueue a live entry (caller guarantees ready)
//   pop                   : dequeue the head (caller guarantees !empty)
//   squash, squash_addr   : clear live bit of every held entry with that address
//   ready, empty          : occupancy flags from registered count
//   head                  : entry at the read pointer
//   pend_mask             : registers targeted by live held entries
//   pend_count            : occupied entries, live or squashed
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [AW-1:0]     push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash,
  input  logic [AW-1:0]     squash_addr,
  output logic              ready,
  output logic              empty,
  output wb_entry_t         head,
  output logic [NREG-1:0]   pend_mask,
  output logic [CW-1:0]     pend_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t       entries [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // Storage, pointers and count. Squash is applied before the push so an
  // entry written on the same edge as a matching ALU write stays live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int d = 0; d < int'(DEPTH); d++) begin
        entries[d] <= '0;
      end
    end else begin
      if (squash) begin
        for (int d = 0; d < int'(DEPTH); d++) begin
          if (entries[d].addr == squash_addr) begin
            entries[d].live <= 1'b0;
          end
        end
      end
      // Freed slots drop their live bit so pend_mask only sees occupied entries.
      if (pop) begin
        entries[rd_ptr].live <= 1'b0;
        rd_ptr               <= rd_ptr + PW'(1);
      end
      if (push) begin
        entries[wr_ptr] <= '{live: 1'b1, addr: push_addr, data: push_data};
        wr_ptr          <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Status derived from registered state only.
  always_comb begin
    ready      = (count < CW'(DEPTH));
    empty      = (count == '0);
    head       = entries[rd_ptr];
    pend_count = count;
    pend_mask  = '0;
    for (int d = 0; d < int'(DEPTH); d++) begin
      if (entries[d].live) begin
        pend_mask[entries[d].addr] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-back stage feeding the register block: picks at most one write per
// cycle (ALU first, then FIFO head) and builds next-state D for every register.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   alu_wr_valid/addr/data       : fixed-timing ALU write
//   mem_wr_valid/ready/addr/data : load return handshake into the FIFO
//   regs_cur                     : current register Q values, r1 in [15:0]
//   regs_next                    : D values, same packing (combinational)
//   pend_mask, pend_count        : pending-write scoreboard for hazard logic
//   wb_idle                      : FIFO empty and no ALU write this cycle
module reg_writeback_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wr_valid,
  input  logic [AW-1:0]          alu_wr_addr,
  input  logic [DATA_W-1:0]      alu_wr_data,
  input  logic                   mem_wr_valid,
  output logic                   mem_wr_ready,
  input  logic [AW-1:0]          mem_wr_addr,
  input  logic [DATA_W-1:0]      mem_wr_data,
  input  logic [NREG*DATA_W-1:0] regs_cur,
  output logic [NREG*DATA_W-1:0] regs_next,
  output logic [NREG-1:0]        pend_mask,
  output logic [CW-1:0]          pend_count,
  output logic                   wb_idle
);

  logic              push;
  logic              pop;
  logic              empty;
  wb_entry_t         head;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign push = mem_wr_valid && mem_wr_ready;
  // A squashed head is still popped; it just produces no write.
  assign pop  = !alu_wr_valid && !empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (mem_wr_addr),
    .push_data   (mem_wr_data),
    .pop         (pop),
    .squash      (alu_wr_valid),
    .squash_addr (alu_wr_addr),
    .ready       (mem_wr_ready),
    .empty       (empty),
    .head        (head),
    .pend_mask   (pend_mask),
    .pend_count  (pend_count)
  );

  // Single write-port arbitration.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (alu_wr_valid) begin
      wr_en   = 1'b1;
      wr_addr = alu_wr_addr;
      wr_data = alu_wr_data;
    end else if (!empty && head.live) begin
      wr_en   = 1'b1;
      wr_addr = head.addr;
      wr_data = head.data;
    end
  end

  // Selected register takes the write; all others recirculate their Q.
  always_comb begin
    regs_next = regs_cur;
    for (int i = 0; i < int'(NREG); i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        regs_next[i*int'(DATA_W) +: int'(DATA_W)] = wr_data;
      end
    end
  end

  assign wb_idle = empty && !alu_wr_valid;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: a queue model of pending memory
// writes predicts each cycle's register write and scoreboard outputs.
module tb_reg_writeback_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic        live;
    logic [2:0]  addr;
    logic [15:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_wr_valid = 1'b0;
  logic [2:0]   alu_wr_addr = '0;
  logic [15:0]  alu_wr_data = '0;
  logic         mem_wr_valid = 1'b0;
  logic         mem_wr_ready;
  logic [2:0]   mem_wr_addr = '0;
  logic [15:0]  mem_wr_data = '0;
  logic [127:0] regs_cur = '0;
  logic [127:0] regs_next;
  logic [7:0]   pend_mask;
  logic [2:0]   pend_count;
  logic         wb_idle;
  logic         load_init = 1'b1;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t sb[$];

  reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wr_valid (alu_wr_valid),
    .alu_wr_addr  (alu_wr_addr),
    .alu_wr_data  (alu_wr_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .regs_cur     (regs_cur),
    .regs_next    (regs_next),
    .pend_mask    (pend_mask),
    .pend_count   (pend_count),
    .wb_idle      (wb_idle)
  );

  always #5 clk = ~clk;

  // Register block model: loads D every clock.
  always @(posedge clk) begin
    if (load_init) regs_cur <= {8{16'h1111}};
    else           regs_cur <= regs_next;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input logic av);
    logic [7:0] exp_mask;
    exp_mask = '0;
    foreach (sb[i]) if (sb[i].live) exp_mask[sb[i].addr] = 1'b1;
    check_eq("mem_wr_ready", 128'(mem_wr_ready), 128'(sb.size() < DEPTH));
    check_eq("pend_count", 128'(pend_count), 128'(sb.size()));
    check_eq("pend_mask", 128'(pend_mask), 128'(exp_mask));
    check_eq("wb_idle", 128'(wb_idle), 128'(sb.size() == 0 && !av));
  endtask

  // One cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [15:0] md);
    logic [127:0] exp_next;
    logic         exp_ready;
    ent_t         e;
    alu_wr_valid = av;
    alu_wr_addr  = aa;
    alu_wr_data  = ad;
    mem_wr_valid = mv;
    mem_wr_addr  = ma;
    mem_wr_data  = md;
    @(negedge clk);
    exp_ready = (sb.size() < DEPTH);
    exp_next  = regs_cur;
    if (av) exp_next[int'(aa)*16 +: 16] = ad;
    else if (sb.size() > 0 && sb[0].live) exp_next[int'(sb[0].addr)*16 +: 16] = sb[0].data;
    check_eq("regs_next", regs_next, exp_next);
    check_status(av);
    @(posedge clk);
    if (!av && sb.size() > 0) void'(sb.pop_front());
    if (av) foreach (sb[i]) if (sb[i].addr == aa) sb[i].live = 1'b0;
    if (mv && exp_ready) begin
      e.live = 1'b1;
      e.addr = ma;
      e.data = md;
      sb.push_back(e);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state with all registers at 0x1111.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_regs_next", regs_next, {8{16'h1111}});
    check_status(1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    load_init = 1'b0;

    // ALU write r3 (addr 2).
    step(1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    check_eq("alu_r3", 128'(regs_cur[47:32]), 128'(16'hBEEF));

    // Fill FIFO while the ALU holds the port, then an offer that must be refused.
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'd7, 16'hC000 + 16'(i), 1'b1, 3'(i), 16'hA000 + 16'(i));
    step(1'b1, 3'd7, 16'hC0FF, 1'b1, 3'd4, 16'hDEAD);
    check_eq("full_mask", 128'(pend_mask), 128'(8'h0F));
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++)
      check_eq("drain_val", 128'(regs_cur[i*16 +: 16]), 128'(16'hA000 + 16'(i)));

    // Squash: older load to addr 5 overtaken by ALU write to addr 5.
    step(1'b1, 3'd6, 16'h0006, 1'b1, 3'd5, 16'h1234);
    step(1'b1, 3'd5, 16'h5678, 1'b0, 3'd0, 16'h0);
    step(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'h0);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    check_eq("squash_r6", 128'(regs_cur[95:80]), 128'(16'h5678));

    // Same-cycle push and ALU write to addr 1: load is younger and lands later.
    step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd1, 16'hBBBB);
    check_eq("same_alu", 128'(regs_cur[31:16]), 128'(16'hAAAA));
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    check_eq("same_mem", 128'(regs_cur[31:16]), 128'(16'hBBBB));

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd0, 16'h0F00 + 16'(i), 1'b1, 3'd2, 16'hD000 + 16'(i));
    alu_wr_valid = 1'b0;
    mem_wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    sb.delete();
    check_eq("midrst_regs", regs_next, regs_cur);
    check_status(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // Random mix.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 99) < 45), 3'($urandom), 16'($urandom),
           1'($urandom_range(0, 99) < 60), 3'($urandom), 16'($urandom));
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
